fc_argmax_classifier: RTL and testbench

//  Final classification stage, directly downstream of the last FC layer (FC3).

---
 rtl/fc_argmax_classifier.sv | 92 +++++++++
 tb/tb_fc_argmax_classifier.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_classifier.sv
// Argmax stage after FC3: streams NUM_CLASS signed scores per frame and reports
// the winning class index and score through a one-entry valid/ready result register.
module fc_argmax_classifier #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CLASS  = 40,
  parameter int unsigned IDX_WIDTH  = 6,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  res_ready,
  output logic                  res_valid,
  output logic [IDX_WIDTH-1:0]  res_class,
  output logic [DATA_WIDTH-1:0] res_score,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASS - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                state;
  logic [IDX_WIDTH-1:0]  elem;
  logic [IDX_WIDTH-1:0]  max_idx;
  logic [DATA_WIDTH-1:0] max_val;

  logic                  start;
  logic                  last;
  logic                  complete;
  logic                  can_load;
  logic [DATA_WIDTH-1:0] cand_val;
  logic [IDX_WIDTH-1:0]  cand_idx;

  // Running max including the current beat; a frame's first beat always wins.
  always_comb begin
    start    = (state == IDLE);
    last     = start ? (NUM_CLASS == 1) : (elem == LAST_IDX);
    complete = in_valid && last;
    can_load = !res_valid || res_ready;
    cand_val = max_val;
    cand_idx = max_idx;
    if (start || ($signed(data_in) > $signed(max_val))) begin
      cand_val = data_in;
      cand_idx = start ? '0 : elem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      elem      <= '0;
      max_idx   <= '0;
      max_val   <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_class <= '0;
      res_score <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      if (in_valid) begin
        max_val <= cand_val;
        max_idx <= cand_idx;
        if (complete) begin
          state     <= IDLE;
          busy      <= 1'b0;
          elem      <= '0;
          frame_cnt <= frame_cnt + CNT_WIDTH'(1);
        end else begin
          state <= ACCUM;
          busy  <= 1'b1;
          elem  <= elem + IDX_WIDTH'(1);
        end
      end
      // Result register: a completion loads if the slot is free or draining this cycle.
      if (complete && can_load) begin
        res_valid <= 1'b1;
        res_class <= cand_idx;
        res_score <= cand_val;
      end else if (complete) begin
        overrun <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Self-checking bench for fc_argmax_classifier against a frame-level argmax model.
module tb_fc_argmax_classifier;

  localparam int NC = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic        res_ready = 1'b0;
  logic        res_valid;
  logic [5:0]  res_class;
  logic [31:0] res_score;
  logic [15:0] frame_cnt;
  logic        busy;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  // Model state: scores of the current partial frame plus the expected result register.
  logic signed [31:0] mq[$];
  logic        exp_valid;
  logic [5:0]  exp_class;
  logic [31:0] exp_score;
  logic [15:0] exp_cnt;
  logic        exp_over;

  fc_argmax_classifier dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .res_ready(res_ready), .res_valid(res_valid), .res_class(res_class),
    .res_score(res_score), .frame_cnt(frame_cnt), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic rs, input logic v, input logic [31:0] d, input logic r);
    int best;
    if (rs) begin
      mq.delete();
      exp_valid = 1'b0; exp_class = '0; exp_score = '0; exp_cnt = '0; exp_over = 1'b0;
      return;
    end
    if (v) mq.push_back(d);
    if (v && mq.size() == NC) begin
      best = 0;
      for (int i = 1; i < NC; i++) if (mq[i] > mq[best]) best = i;
      exp_cnt = exp_cnt + 16'd1;
      if (!exp_valid || r) begin
        exp_valid = 1'b1; exp_class = 6'(best); exp_score = mq[best];
      end else begin
        exp_over = 1'b1;
      end
      mq.delete();
    end else if (exp_valid && r) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic cycle(input logic rs, input logic v, input logic [31:0] d, input logic r);
    rst = rs; in_valid = v; data_in = d; res_ready = r;
    model_step(rs, v, d, r);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_score();
    if ($urandom_range(0, 1) == 1) return $urandom;
    return 32'($urandom_range(0, 6)) - 32'd3;
  endfunction

  task automatic test_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 1, 32'd7, 0);
    cycle(0, 0, 0, 0);
    checks++;
    if ({res_valid, res_class, res_score, frame_cnt, busy, overrun} !== '0) begin
      errors++;
      $display("FAIL reset: got valid=%0b class=%0d score=%0h cnt=%0d busy=%0b ovr=%0b, want all zero",
               res_valid, res_class, res_score, frame_cnt, busy, overrun);
    end
  endtask

  task automatic test_ascending();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < NC; i++) begin
      cycle(0, 1, 32'(i), 1);
      if (i == 5) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %0b want 1", busy); end
      end
    end
    checks++;
    if (res_valid !== 1'b1 || res_class !== 6'd39 || res_score !== 32'd39 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL t1_result: got v=%0b c=%0d s=%0d n=%0d want v=1 c=39 s=39 n=1",
               res_valid, res_class, res_score, frame_cnt);
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL t1_pulse: got v=%0b busy=%0b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_negative_and_tie();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < NC; i++) cycle(0, 1, (i == 7) ? 32'hFFFF_FFFF : 32'hFFFF_FFFB, 1);
    checks++;
    if (res_valid !== 1'b1 || res_class !== 6'd7 || res_score !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL t2_neg: got v=%0b c=%0d s=%0h want v=1 c=7 s=ffffffff", res_valid, res_class, res_score);
    end
    for (int i = 0; i < NC; i++) cycle(0, 1, 32'd100, 1);
    checks++;
    if (res_valid !== 1'b1 || res_class !== 6'd0 || res_score !== 32'd100) begin
      errors++;
      $display("FAIL t2_tie: got v=%0b c=%0d s=%0d want v=1 c=0 s=100", res_valid, res_class, res_score);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3 * NC; i++) begin
      cycle(0, 1, rand_score(), 1);
      checks++;
      if (res_valid !== ((i % NC) == NC - 1) || (res_valid && (res_class !== exp_class || res_score !== exp_score))) begin
        errors++;
        $display("FAIL t3_beat%0d: got v=%0b c=%0d s=%0h want v=%0b c=%0d s=%0h",
                 i, res_valid, res_class, res_score, (i % NC) == NC - 1, exp_class, exp_score);
      end
    end
    checks++;
    if (frame_cnt !== 16'd3 || overrun !== 1'b0) begin
      errors++; $display("FAIL t3_end: got n=%0d ovr=%0b want n=3 ovr=0", frame_cnt, overrun);
    end
  endtask

  task automatic test_overrun();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < NC; i++) cycle(0, 1, (i == 3) ? 32'd5000 : 32'(i), 0);
    for (int i = 0; i < NC; i++) cycle(0, 1, (i == 12) ? 32'd9000 : 32'(i), 0);
    checks++;
    if (res_valid !== 1'b1 || res_class !== 6'd3 || res_score !== 32'd5000 || overrun !== 1'b1 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL t4_hold: got v=%0b c=%0d s=%0d ovr=%0b n=%0d want v=1 c=3 s=5000 ovr=1 n=2",
               res_valid, res_class, res_score, overrun, frame_cnt);
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (res_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("FAIL t4_drain: got v=%0b ovr=%0b want v=0 ovr=1", res_valid, overrun);
    end
  endtask

  task automatic test_simultaneous();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < NC; i++) cycle(0, 1, (i == 20) ? 32'd77 : 32'd1, 0);
    for (int i = 0; i < NC; i++) cycle(0, 1, (i == 30) ? 32'd88 : 32'd2, i == NC - 1);
    checks++;
    if (res_valid !== 1'b1 || res_class !== 6'd30 || res_score !== 32'd88 || overrun !== 1'b0 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL t5: got v=%0b c=%0d s=%0d ovr=%0b n=%0d want v=1 c=30 s=88 ovr=0 n=2",
               res_valid, res_class, res_score, overrun, frame_cnt);
    end
  endtask

  task automatic test_midframe_reset();
    int beats;
    cycle(1, 0, 0, 0);
    beats = 0;
    while (beats < 20) begin
      if ($urandom_range(0, 2) == 0) cycle(0, 0, $urandom, 1);
      else begin cycle(0, 1, rand_score(), 1); beats++; end
    end
    cycle(1, 0, 0, 1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy: got %0b want 0", busy); end
    beats = 0;
    while (beats < NC) begin
      if ($urandom_range(0, 2) == 0) cycle(0, 0, $urandom, 0);
      else begin cycle(0, 1, rand_score(), 0); beats++; end
    end
    checks++;
    if (res_valid !== 1'b1 || res_class !== exp_class || res_score !== exp_score || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL t6_frame: got v=%0b c=%0d s=%0h n=%0d want v=1 c=%0d s=%0h n=1",
               res_valid, res_class, res_score, frame_cnt, exp_class, exp_score);
    end
  endtask

  task automatic test_random();
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      cycle(0, $urandom_range(0, 3) != 0, rand_score(), $urandom_range(0, 2) != 0);
      checks++;
      if (res_valid !== exp_valid || frame_cnt !== exp_cnt || overrun !== exp_over ||
          busy !== (mq.size() != 0) || (exp_valid && (res_class !== exp_class || res_score !== exp_score))) begin
        errors++;
        $display("FAIL rand_cyc%0d: got v=%0b c=%0d s=%0h n=%0d o=%0b b=%0b want v=%0b c=%0d s=%0h n=%0d o=%0b b=%0b",
                 k, res_valid, res_class, res_score, frame_cnt, overrun, busy,
                 exp_valid, exp_class, exp_score, exp_cnt, exp_over, mq.size() != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_negative_and_tie();
    test_back_to_back();
    test_overrun();
    test_simultaneous();
    test_midframe_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
